branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Next-generation branch unit: resolves unconditional, branch-if-zero and branch-if-nonzero
//  outcomes and drives PC_src_out to the PC mux.
//  Adds a bimodal predictor: a table of 2^IDX_W saturating counters indexed by PC, read at
//  fetch and trained at resolve.
//  Flags mispredicts for pipeline flush, keeps saturating statistics counters, and provides a
//  sequential table-clear FSM.
// PARAMETERS
//  PC_W    64  program counter width
//  IDX_W   6   table index bits; depth = 2^IDX_W entries
//  CNT_W   2   predictor counter width (>=2); taken when MSB=1
//  STAT_W  32  width of statistics counters
// PORTS
//  clk                      in   1       rising-edge clock
//  rst_n                    in   1       asynchronous active-low reset
//  lookup_valid             in   1       fetch-stage prediction request
//  lookup_pc                in   PC_W    fetch PC
//  pred_valid               out  1       pred_taken is valid (1 cycle after lookup_valid)
//  pred_taken               out  1       predicted direction
//  resolve_valid            in   1       execute-stage branch resolution this cycle
//  resolve_pc               in   PC_W    PC of resolving branch
//  unconditional_branch_in  in   1       unconditional branch
//  conditional_branch_in    in   1       conditional branch
//  cond_invert_in           in   1       1 = branch-if-nonzero, 0 = branch-if-zero
//  alu_main_is_zero         in   1       ALU zero flag
//  resolve_pred_taken       in   1       prediction carried down the pipe with this branch
//  PC_src_out               out  1       actual taken (combinational)
//  mispredict_out           out  1       actual != predicted (combinational)
//  clr_req                  in   1       start table clear (pulse)
//  busy_out                 out  1       clear FSM active
//  branch_cnt               out  STAT_W  resolved branches (saturating)
//  mispredict_cnt           out  STAT_W  mispredicts (saturating)
// BEHAVIOUR
//  - idx = pc[IDX_W+1:2]. Lower 2 PC bits are ignored (word-aligned).
//  - cond_taken = conditional_branch_in & (alu_main_is_zero ^ cond_invert_in).
//  - taken = unconditional_branch_in | cond_taken.
//  - PC_src_out = resolve_valid & taken.
//  - mispredict_out = resolve_valid & (taken != resolve_pred_taken). Both outputs are
//    combinational, with zero-cycle latency.
//  - Prediction: registered, 1-cycle latency. pred_valid <= lookup_valid & ~busy.
//    pred_taken <= MSB of table[idx(lookup_pc)], or 0 while busy.
//  - Training: on a clk edge with resolve_valid & (uncond | cond) & ~busy, table[idx] steps
//    +1 if taken, else -1. Steps saturate at 0 and at 2^CNT_W-1. Non-branch resolves do not
//    train.
//  - Same-cycle lookup and train to the same idx: the prediction returns the pre-update value.
//    There is no bypass.
//  - Stats update when resolve_valid & (uncond | cond), including while busy:
//    - branch_cnt += 1;
//    - mispredict_cnt += mispredict_out.
//    Both hold at all-ones (no wrap).
//  - FSM:
//    - IDLE: on clr_req go to CLEAR with ptr = 0.
//    - CLEAR: write table[ptr] = weakly-not-taken (2^(CNT_W-1)-1), ptr += 1. When
//      ptr = 2^IDX_W-1 is written, return to IDLE. Clear takes 2^IDX_W cycles.
//    - busy_out = (state == CLEAR).
//    - clr_req during CLEAR is ignored.
//  - Reset (rst_n = 0, async):
//    - all table entries = weakly-not-taken;
//    - state = IDLE, ptr = 0;
//    - pred_valid = 0, pred_taken = 0;
//    - counters = 0.
//    Reset mid-clear aborts the clear; the table is fully reinitialised by reset itself.
//  - Combinational outputs depend only on inputs and are unaffected by busy.
// TESTING
//  1. Reset, then lookup pc=0x40 -> next cycle pred_valid=1, pred_taken=0.
//     All stats counters = 0.
//  2. Resolve cond, zero=1, invert=0, pred=0, pc=0x40 -> PC_src_out=1, mispredict_out=1.
//     Repeat once; a lookup at 0x40 then gives pred_taken=1, and mispredict_cnt=2.
//  3. Resolve cond, invert=1, zero=0 -> taken. Uncond with any zero -> taken.
//     cond=uncond=0 -> PC_src_out=0, no training, branch_cnt unchanged.
//  4. Train idx 5 taken x4, then not-taken x1 -> prediction stays 1.
//     A same-cycle lookup and train at idx 5 returns the old value.
//  5. Pulse clr_req -> busy_out=1 for exactly 2^IDX_W cycles, pred_taken forced 0,
//     training ignored. Afterwards all entries predict 0. A second clr_req mid-clear has
//     no effect.
//  6. Drop rst_n mid-clear -> busy_out=0 immediately. Preload stats near all-ones ->
//     counters saturate.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side bundle of the branch predict unit: lookup request/response and
// branch resolution with its combinational redirect and mispredict flags.
interface branch_predict_unit_if #(
    parameter int PC_W = 64
);
    logic            lookup_valid;
    logic [PC_W-1:0] lookup_pc;
    logic            pred_valid;
    logic            pred_taken;

    logic            resolve_valid;
    logic [PC_W-1:0] resolve_pc;
    logic            unconditional_branch_in;
    logic            conditional_branch_in;
    logic            cond_invert_in;
    logic            alu_main_is_zero;
    logic            resolve_pred_taken;
    logic            PC_src_out;
    logic            mispredict_out;

    modport master (
        output lookup_valid, lookup_pc,
        output resolve_valid, resolve_pc, unconditional_branch_in, conditional_branch_in,
        output cond_invert_in, alu_main_is_zero, resolve_pred_taken,
        input  pred_valid, pred_taken, PC_src_out, mispredict_out
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  resolve_valid, resolve_pc, unconditional_branch_in, conditional_branch_in,
        input  cond_invert_in, alu_main_is_zero, resolve_pred_taken,
        output pred_valid, pred_taken, PC_src_out, mispredict_out
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolve logic plus a bimodal predictor (PC-indexed saturating counters), saturating
// branch/mispredict statistics and a sequential table-clear FSM.
module branch_predict_unit #(
    parameter int PC_W   = 64,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int STAT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_predict_unit_if.slave   bus,
    input  logic                   clr_req,
    output logic                   busy_out,
    output logic [STAT_W-1:0]      branch_cnt,
    output logic [STAT_W-1:0]      mispredict_cnt
);
    localparam int               DEPTH   = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WNT     = CNT_W'((1 << (CNT_W - 1)) - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] ctr_step(input logic [CNT_W-1:0] c, input logic up);
        if (up)
            return (c == CNT_MAX) ? c : c + CNT_W'(1);
        else
            return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    function automatic logic [STAT_W-1:0] stat_add(input logic [STAT_W-1:0] c, input logic inc);
        return (inc && (c != '1)) ? c + STAT_W'(1) : c;
    endfunction

    logic [CNT_W-1:0] table_q [DEPTH];
    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             pred_valid_p1, pred_taken_p1;
    logic [STAT_W-1:0] branch_cnt_q, mispredict_cnt_q;

    logic [IDX_W-1:0] lookup_idx, resolve_idx;
    logic             cond_taken, taken, is_branch, mispredict, busy, train;

    assign lookup_idx  = bus.lookup_pc[IDX_W+1:2];
    assign resolve_idx = bus.resolve_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc[PC_W-1:IDX_W+2], bus.lookup_pc[1:0],
                              bus.resolve_pc[PC_W-1:IDX_W+2], bus.resolve_pc[1:0]};

    assign cond_taken = bus.conditional_branch_in & (bus.alu_main_is_zero ^ bus.cond_invert_in);
    assign taken      = bus.unconditional_branch_in | cond_taken;
    assign is_branch  = bus.resolve_valid & (bus.unconditional_branch_in | bus.conditional_branch_in);
    assign mispredict = bus.resolve_valid & (taken != bus.resolve_pred_taken);

    assign bus.PC_src_out     = bus.resolve_valid & taken;
    assign bus.mispredict_out = mispredict;

    assign busy  = (state_q == S_CLEAR);
    assign train = is_branch & ~busy;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Clear sweep owns the table while busy; otherwise resolved branches train it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                table_q[i] <= WNT;
        end else if (busy) begin
            table_q[ptr_q] <= WNT;
        end else if (train) begin
            table_q[resolve_idx] <= ctr_step(table_q[resolve_idx], taken);
        end
    end

    // Stage p1: prediction reads the pre-update table, no bypass from training.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_p1 <= 1'b0;
            pred_taken_p1 <= 1'b0;
        end else begin
            pred_valid_p1 <= bus.lookup_valid & ~busy;
            pred_taken_p1 <= busy ? 1'b0 : table_q[lookup_idx][CNT_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (is_branch) begin
            branch_cnt_q     <= stat_add(branch_cnt_q, 1'b1);
            mispredict_cnt_q <= stat_add(mispredict_cnt_q, mispredict);
        end
    end

    assign bus.pred_valid  = pred_valid_p1;
    assign bus.pred_taken  = pred_taken_p1;
    assign busy_out        = busy;
    assign branch_cnt      = branch_cnt_q;
    assign mispredict_cnt  = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed steps plus random traffic against a table-of-ints model.
module tb_branch_predict_unit;
    localparam int PC_W     = 64;
    localparam int IDX_W    = 6;
    localparam int CNT_W    = 2;
    localparam int STAT_W   = 4;
    localparam int DEPTH    = 64;
    localparam int CMAX     = 3;
    localparam int WNT      = 1;
    localparam int STAT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr_req = 1'b0;
    logic              busy_out;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] mispredict_cnt;

    branch_predict_unit_if #(.PC_W(PC_W)) bus();

    branch_predict_unit #(
        .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .STAT_W(STAT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .clr_req        (clr_req),
        .busy_out       (busy_out),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int tbl [DEPTH];
    int m_bcnt, m_mcnt, m_ptr;
    bit m_busy, m_pv, m_pt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [63:0] pc);
        return int'(pc[IDX_W+1:2]);
    endfunction

    task automatic model_reset();
        foreach (tbl[i]) tbl[i] = WNT;
        m_bcnt = 0; m_mcnt = 0; m_ptr = 0;
        m_busy = 0; m_pv = 0; m_pt = 0;
    endtask

    task automatic set_in(input bit lv, input logic [63:0] lpc, input bit rv, input logic [63:0] rpc,
                          input bit u, input bit c, input bit inv, input bit z, input bit rpt,
                          input bit clr);
        bus.lookup_valid            = lv;
        bus.lookup_pc               = lpc;
        bus.resolve_valid           = rv;
        bus.resolve_pc              = rpc;
        bus.unconditional_branch_in = u;
        bus.conditional_branch_in   = c;
        bus.cond_invert_in          = inv;
        bus.alu_main_is_zero        = z;
        bus.resolve_pred_taken      = rpt;
        clr_req                     = clr;
    endtask

    task automatic set_idle();
        set_in(0, 64'h0, 0, 64'h0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_random(input int clr_odds);
        set_in(1'($urandom_range(0, 1)), 64'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 64'($urandom_range(0, 255)),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, clr_odds) == 0));
    endtask

    // Inputs are already driven (after a negedge); check comb outputs, advance model, clock once.
    task automatic cycle();
        bit taken, exp_src, exp_mp, is_br, pv_n, pt_n;
        int ri;
        #1;
        taken   = bus.unconditional_branch_in |
                  (bus.conditional_branch_in & (bus.alu_main_is_zero ^ bus.cond_invert_in));
        exp_src = bus.resolve_valid & taken;
        exp_mp  = bus.resolve_valid & (taken != bus.resolve_pred_taken);
        check("pc_src", 64'(bus.PC_src_out), 64'(exp_src));
        check("mispredict", 64'(bus.mispredict_out), 64'(exp_mp));

        pv_n  = bus.lookup_valid & !m_busy;
        pt_n  = m_busy ? 1'b0 : (tbl[idx_of(bus.lookup_pc)] >= 2);
        is_br = bus.resolve_valid & (bus.unconditional_branch_in | bus.conditional_branch_in);
        if (is_br) begin
            if (m_bcnt < STAT_MAX) m_bcnt++;
            if (exp_mp && m_mcnt < STAT_MAX) m_mcnt++;
        end
        if (m_busy) begin
            tbl[m_ptr] = WNT;
            m_ptr++;
            if (m_ptr == DEPTH) begin m_busy = 0; m_ptr = 0; end
        end else begin
            if (is_br) begin
                ri = idx_of(bus.resolve_pc);
                if (taken) tbl[ri] = (tbl[ri] < CMAX) ? tbl[ri] + 1 : CMAX;
                else       tbl[ri] = (tbl[ri] > 0) ? tbl[ri] - 1 : 0;
            end
            if (clr_req) begin m_busy = 1; m_ptr = 0; end
        end
        m_pv = pv_n;
        m_pt = pt_n;

        @(posedge clk);
        @(negedge clk);
        check("pred_valid", 64'(bus.pred_valid), 64'(m_pv));
        check("pred_taken", 64'(bus.pred_taken), 64'(m_pt));
        check("busy", 64'(busy_out), 64'(m_busy));
        check("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
        check("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mcnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        int guard;

        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_branch_cnt", 64'(branch_cnt), 64'd0);
        check("rst_mispredict_cnt", 64'(mispredict_cnt), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);

        // Lookup after reset predicts not-taken.
        set_in(1, 64'h40, 0, 64'h0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("t1_pred_valid", 64'(bus.pred_valid), 64'd1);
        check("t1_pred_taken", 64'(bus.pred_taken), 64'd0);

        // Branch-if-zero with zero set, predicted not-taken, twice.
        repeat (2) begin
            set_in(0, 64'h0, 1, 64'h40, 0, 1, 0, 1, 0, 0);
            #1;
            check("t2_pc_src", 64'(bus.PC_src_out), 64'd1);
            check("t2_mispredict", 64'(bus.mispredict_out), 64'd1);
            cycle();
        end
        set_in(1, 64'h40, 0, 64'h0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("t2_pred_taken", 64'(bus.pred_taken), 64'd1);
        check("t2_mispredict_cnt", 64'(mispredict_cnt), 64'd2);

        // Branch-if-nonzero, unconditional, and non-branch resolve.
        set_in(0, 64'h0, 1, 64'h80, 0, 1, 1, 0, 1, 0);
        #1; check("t3_nonzero_taken", 64'(bus.PC_src_out), 64'd1);
        cycle();
        set_in(0, 64'h0, 1, 64'h84, 1, 0, 0, 0, 1, 0);
        #1; check("t3_uncond_z0", 64'(bus.PC_src_out), 64'd1);
        cycle();
        set_in(0, 64'h0, 1, 64'h84, 1, 0, 0, 1, 1, 0);
        #1; check("t3_uncond_z1", 64'(bus.PC_src_out), 64'd1);
        cycle();
        check("t3_branch_cnt", 64'(branch_cnt), 64'd5);
        set_in(0, 64'h0, 1, 64'h88, 0, 0, 1, 0, 0, 0);
        #1; check("t3_nonbranch", 64'(bus.PC_src_out), 64'd0);
        cycle();
        check("t3_branch_cnt_hold", 64'(branch_cnt), 64'd5);

        // idx 5: taken x4 then not-taken x1, prediction remains taken.
        repeat (4) begin
            set_in(0, 64'h0, 1, 64'h14, 1, 0, 0, 0, 1, 0);
            cycle();
        end
        set_in(0, 64'h0, 1, 64'h14, 0, 1, 0, 0, 1, 0);
        cycle();
        set_in(1, 64'h14, 0, 64'h0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("t4_pred_after_nt", 64'(bus.pred_taken), 64'd1);
        set_in(1, 64'h14, 1, 64'h14, 0, 1, 0, 0, 1, 0);
        cycle();
        check("t4_same_cycle_old", 64'(bus.pred_taken), 64'd1);
        set_in(1, 64'h14, 0, 64'h0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("t4_after_update", 64'(bus.pred_taken), 64'd0);

        // Table clear: busy length, forced not-taken, training ignored, re-request ignored.
        set_in(0, 64'h0, 0, 64'h0, 0, 0, 0, 0, 0, 1);
        cycle();
        busy_cycles = busy_out ? 1 : 0;
        guard = 0;
        while (busy_out && guard < 200) begin
            set_in(1, 64'h40, 1, 64'h40, 1, 0, 0, 0, 0, guard == 10);
            cycle();
            check("t5_forced_nt", 64'(bus.pred_taken), 64'd0);
            if (busy_out) busy_cycles++;
            guard++;
        end
        check("t5_busy_cycles", 64'(busy_cycles), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 64'(i << 2), 0, 64'h0, 0, 0, 0, 0, 0, 0);
            cycle();
            check("t5_cleared", 64'(bus.pred_taken), 64'd0);
        end

        // Reset mid-clear, then stats saturation.
        set_in(0, 64'h0, 0, 64'h0, 0, 0, 0, 0, 0, 1);
        cycle();
        set_idle();
        repeat (5) cycle();
        rst_n = 1'b0;
        #1;
        check("t6_busy_async", 64'(busy_out), 64'd0);
        check("t6_pred_valid_rst", 64'(bus.pred_valid), 64'd0);
        check("t6_branch_cnt_rst", 64'(branch_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            set_in(0, 64'h0, 1, 64'h20, 1, 0, 0, 0, 0, 0);
            cycle();
        end
        check("t6_branch_sat", 64'(branch_cnt), 64'(STAT_MAX));
        check("t6_mispredict_sat", 64'(mispredict_cnt), 64'(STAT_MAX));

        // Random traffic against the model, starting from a fresh table.
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            set_random(60);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
